// File: rtl/draw_seq_pkg.sv
// Shared state encoding and default widths for the draw layer sequencer.
package draw_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        SELECT,
        ISSUE,
        WAIT_DONE
    } seq_state_t;

    localparam int DEF_CLOCK_FREQ  = 50000000;
    localparam int DEF_FRAME_RATE  = 10;
    localparam int DEF_NUM_LAYERS  = 4;
    localparam int DEF_X_WIDTH     = 9;
    localparam int DEF_Y_WIDTH     = 10;
    localparam int DEF_ID_WIDTH    = 4;
    localparam int DEF_SCROLL_WRAP = 32;

endpackage

// File: rtl/draw_layer_sequencer_if.sv
// Draw/ready handshake bundle between the sequencer and the drawing engine.
interface draw_layer_sequencer_if
    import draw_seq_pkg::*;
#(
    parameter int X_WIDTH  = DEF_X_WIDTH,
    parameter int Y_WIDTH  = DEF_Y_WIDTH,
    parameter int ID_WIDTH = DEF_ID_WIDTH
);
    logic                       draw;
    logic                       ready;
    logic signed [X_WIDTH-1:0]  x_origin;
    logic signed [Y_WIDTH-1:0]  y_origin;
    logic        [ID_WIDTH-1:0] rom_id;

    modport master (
        output draw,
        output x_origin,
        output y_origin,
        output rom_id,
        input  ready
    );

    modport slave (
        input  draw,
        input  x_origin,
        input  y_origin,
        input  rom_id,
        output ready
    );
endinterface

// File: rtl/frame_tick_divider.sv
// Free-running divider producing a one-cycle frame tick every
// CLOCK_FREQ/FRAME_RATE clocks.
module frame_tick_divider
    import draw_seq_pkg::*;
#(
    parameter int CLOCK_FREQ = DEF_CLOCK_FREQ,
    parameter int FRAME_RATE = DEF_FRAME_RATE
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int DIV = CLOCK_FREQ / FRAME_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);
endmodule

// File: rtl/draw_layer_sequencer.sv
// Frame-rate layer sequencer: one update request and N back-to-front draws
// per tick. Define FRAME_OVERRUN_COUNT_EN to count dropped ticks.
module draw_layer_sequencer
    import draw_seq_pkg::*;
#(
    parameter int CLOCK_FREQ  = DEF_CLOCK_FREQ,
    parameter int FRAME_RATE  = DEF_FRAME_RATE,
    parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
    parameter int X_WIDTH     = DEF_X_WIDTH,
    parameter int Y_WIDTH     = DEF_Y_WIDTH,
    parameter int ID_WIDTH    = DEF_ID_WIDTH,
    parameter int SCROLL_WRAP = DEF_SCROLL_WRAP
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS*X_WIDTH-1:0]  layer_x,
    input  logic [NUM_LAYERS*Y_WIDTH-1:0]  layer_y,
    input  logic [NUM_LAYERS*ID_WIDTH-1:0] layer_rom,
    input  logic [NUM_LAYERS*Y_WIDTH-1:0]  layer_step,
    input  logic                           update_ack,
    output logic                           update_req,
    draw_layer_sequencer_if.master         dbus,
    output logic                           busy,
    output logic                           frame_done,
    output logic [7:0]                     overrun_count
);
    localparam int IW = $clog2(NUM_LAYERS + 1);
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LAYERS);
    localparam logic signed [Y_WIDTH:0] WRAP_POS = (Y_WIDTH + 1)'(SCROLL_WRAP);
    localparam logic signed [Y_WIDTH:0] WRAP_NEG = -WRAP_POS;

    seq_state_t state;
    seq_state_t state_nx;

    logic          tick;
    logic [IW-1:0] idx;
    logic [LW-1:0] lidx;
    logic          at_end;
    logic          en_sel;

    logic signed [X_WIDTH-1:0]  lx   [NUM_LAYERS];
    logic signed [Y_WIDTH-1:0]  ly   [NUM_LAYERS];
    logic        [ID_WIDTH-1:0] lrom [NUM_LAYERS];
    logic signed [Y_WIDTH-1:0]  lstp [NUM_LAYERS];

    logic signed [Y_WIDTH-1:0] offset [NUM_LAYERS];
    logic signed [Y_WIDTH-1:0] pend_off;
    logic signed [Y_WIDTH-1:0] off_sel;
    logic signed [Y_WIDTH-1:0] stp_sel;
    logic signed [Y_WIDTH:0]   scroll_sum;
    logic                      scroll_wrap;

    frame_tick_divider #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .FRAME_RATE (FRAME_RATE)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            lx[i]   = layer_x[i*X_WIDTH +: X_WIDTH];
            ly[i]   = layer_y[i*Y_WIDTH +: Y_WIDTH];
            lrom[i] = layer_rom[i*ID_WIDTH +: ID_WIDTH];
            lstp[i] = layer_step[i*Y_WIDTH +: Y_WIDTH];
        end
    end

    assign lidx   = idx[LW-1:0];
    assign at_end = (idx == LAST_IDX);
    assign en_sel = layer_en[lidx];

    // Next offset is resolved in SELECT so the step is sampled with the rest
    // of the layer inputs, then committed once the engine finishes the draw.
    assign off_sel     = offset[lidx];
    assign stp_sel     = lstp[lidx];
    assign scroll_sum  = {off_sel[Y_WIDTH-1], off_sel}
                       + {stp_sel[Y_WIDTH-1], stp_sel};
    assign scroll_wrap = (scroll_sum <= WRAP_NEG) || (scroll_sum >= WRAP_POS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        update_req = 1'b0;
        dbus.draw  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (tick && enable) state_nx = UPDATE;
            end
            UPDATE: begin
                update_req = 1'b1;
                if (update_ack) state_nx = SELECT;
            end
            SELECT: begin
                if (at_end) begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end else if (en_sel) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                dbus.draw = 1'b1;
                if (!dbus.ready) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (dbus.ready) state_nx = SELECT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            pend_off      <= '0;
            dbus.x_origin <= '0;
            dbus.y_origin <= '0;
            dbus.rom_id   <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) offset[i] <= '0;
        end else begin
            unique case (1'b1)
                (state == UPDATE) && update_ack: begin
                    idx <= '0;
                end
                (state == SELECT) && !at_end && !en_sel: begin
                    idx <= idx + 1'b1;
                end
                (state == SELECT) && !at_end && en_sel: begin
                    dbus.x_origin <= lx[lidx];
                    dbus.y_origin <= ly[lidx] + off_sel;
                    dbus.rom_id   <= lrom[lidx];
                    pend_off      <= scroll_wrap ? '0
                                   : scroll_sum[Y_WIDTH-1:0];
                end
                (state == WAIT_DONE) && dbus.ready: begin
                    offset[lidx] <= pend_off;
                    idx          <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FRAME_OVERRUN_COUNT_EN
    logic [7:0] ovr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovr_q <= '0;
        end else if (tick && (state != IDLE) && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 1'b1;
        end
    end

    assign overrun_count = ovr_q;
`else
    assign overrun_count = '0;
`endif
endmodule

// File: tb/tb_draw_layer_sequencer.sv
// Scoreboard bench for draw_layer_sequencer: random layer setups per frame,
// expected draws queued from a frame-level model, checked by a monitor.
`timescale 1ns/1ps
module tb_draw_layer_sequencer;
    localparam int N   = 4;
    localparam int XW  = 9;
    localparam int YW  = 10;
    localparam int IDW = 4;
    localparam int CF  = 1000;
    localparam int FR  = 10;
    localparam int WRAP = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic update_ack = 1'b0;
    logic [N-1:0]     layer_en = '0;
    logic [N*XW-1:0]  layer_x = '0;
    logic [N*YW-1:0]  layer_y = '0;
    logic [N*IDW-1:0] layer_rom = '0;
    logic [N*YW-1:0]  layer_step = '0;
    logic update_req;
    logic busy;
    logic frame_done;
    logic [7:0] overrun_count;

    draw_layer_sequencer_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .ID_WIDTH(IDW)) eng ();

    draw_layer_sequencer #(
        .CLOCK_FREQ(CF), .FRAME_RATE(FR), .NUM_LAYERS(N),
        .X_WIDTH(XW), .Y_WIDTH(YW), .ID_WIDTH(IDW), .SCROLL_WRAP(WRAP)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y),
        .layer_rom(layer_rom), .layer_step(layer_step),
        .update_ack(update_ack), .update_req(update_req),
        .dbus(eng), .busy(busy), .frame_done(frame_done),
        .overrun_count(overrun_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit             fd;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
        logic [IDW-1:0] rom;
    } exp_t;

    exp_t exp_q[$];
    int   model_off [N];
    int   vectors = 0;
    int   miscompares = 0;
    int   hold_len = 5;
    int   exp_ov = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Frame model: each enabled layer drawn in index order at base y plus
    // its current offset; offset then advances by step and wraps to zero.
    task automatic do_frame(input logic [N-1:0] en, input bit scroll1);
        int n;
        n = 0;
        while (update_req !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("update_req_seen", update_req, 1);
        for (int i = 0; i < N; i++) begin
            logic [XW-1:0]         cx;
            logic signed [YW-1:0]  cy;
            logic [IDW-1:0]        crom;
            logic signed [YW-1:0]  cstep;
            int s;
            cx    = XW'($urandom);
            cy    = YW'($urandom);
            crom  = IDW'($urandom);
            cstep = YW'(int'($urandom_range(80)) - 40);
            if (scroll1 && i == 1) begin
                cy    = '0;
                cstep = YW'(-5);
                en[1] = 1'b1;
            end
            layer_x[i*XW +: XW]     = cx;
            layer_y[i*YW +: YW]     = cy;
            layer_rom[i*IDW +: IDW] = crom;
            layer_step[i*YW +: YW]  = cstep;
            if (en[i]) begin
                exp_q.push_back('{fd: 1'b0, x: cx,
                                  y: YW'(int'(cy) + model_off[i]),
                                  rom: crom});
                s = model_off[i] + int'(cstep);
                model_off[i] = (s <= -WRAP || s >= WRAP) ? 0 : s;
            end
        end
        layer_en = en;
        exp_q.push_back('{fd: 1'b1, x: '0, y: '0, rom: '0});
        update_ack = 1'b1;
        @(negedge clock);
        update_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("frame_drain", exp_q.size(), 0);
    endtask

    // Drawing engine: drops ready two cycles after a draw, holds it low.
    initial begin
        eng.ready = 1'b1;
        forever begin
            @(negedge clock);
            if (eng.draw === 1'b1 && !reset) begin
                repeat (2) @(negedge clock);
                eng.ready = 1'b0;
                repeat (hold_len) @(negedge clock);
                eng.ready = 1'b1;
            end
        end
    end

    logic draw_q = 1'b0;
    exp_t mon_e;

    always @(negedge clock) begin
        if (reset) begin
            draw_q <= 1'b0;
        end else begin
            draw_q <= eng.draw;
            if (eng.draw === 1'b1 && !draw_q) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL draw_unexpected: draw rom=%0d, none expected",
                             eng.rom_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("draw_slot_kind", mon_e.fd, 0);
                    check("x_origin", $unsigned(eng.x_origin), mon_e.x);
                    check("y_origin", $unsigned(eng.y_origin), mon_e.y);
                    check("rom_id", eng.rom_id, mon_e.rom);
                end
            end
            if (frame_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_done_unexpected: pulse with none expected");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame_done_slot_kind", mon_e.fd, 1);
                end
            end
        end
    end

    initial begin
        int n;
        int viol;
        repeat (3) @(negedge clock);
        check("rst_update_req", update_req, 0);
        check("rst_draw", eng.draw, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun_count, 0);
        check("rst_x", $unsigned(eng.x_origin), 0);
        check("rst_y", $unsigned(eng.y_origin), 0);
        check("rst_rom", eng.rom_id, 0);
        reset  = 1'b0;
        enable = 1'b1;

        repeat (3) do_frame('1, 1'b0);
        repeat (3) do_frame(4'b1010, 1'b0);
        repeat (9) do_frame(N'($urandom), 1'b1);
        repeat (8) do_frame(N'($urandom), 1'b0);
        wait_idle();

        hold_len = 150;
        do_frame(4'b0001, 1'b0);
        wait_idle();
        hold_len = 5;
`ifdef FRAME_OVERRUN_COUNT_EN
        exp_ov = 1;
`else
        exp_ov = 0;
`endif
        check("overrun_long_hold", overrun_count, exp_ov);

        enable = 1'b0;
        viol = 0;
        repeat (320) begin
            @(negedge clock);
            if (update_req !== 1'b0 || eng.draw !== 1'b0 || busy !== 1'b0)
                viol++;
        end
        check("disabled_activity", viol, 0);
        check("disabled_overrun", overrun_count, exp_ov);
        enable = 1'b1;

        do_frame('1, 1'b0);
        n = 0;
        while (eng.draw !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("draw_before_reset", eng.draw, 1);
        reset = 1'b1;
        #1;
        check("reset_draw", eng.draw, 0);
        check("reset_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) model_off[i] = 0;
        exp_ov = 0;
        @(negedge clock);
        check("reset_overrun", overrun_count, exp_ov);
        check("reset_y", $unsigned(eng.y_origin), 0);
        check("reset_update_req", update_req, 0);
        reset = 1'b0;

        do_frame('1, 1'b0);
        do_frame('1, 1'b0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
